// File: rtl/brisc_pkg.sv
// Shared types for the brisc memory subsystem.
// Arbiter states, client ids and the latched memory request bundle.
package brisc_pkg;

  localparam int ARB_CLIENTS = 2;
  localparam int MEM_AW      = 32;
  localparam int MEM_DW      = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  typedef logic client_id_t;

  localparam client_id_t CLIENT_1 = 1'b0;
  localparam client_id_t CLIENT_2 = 1'b1;

  typedef struct packed {
    logic              store;
    logic              word;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] data;
  } mem_req_t;

  function automatic client_id_t rr_other(
    input client_id_t id
  );
    return (id == CLIENT_1) ? CLIENT_2 : CLIENT_1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin select.
// On a tie the client that was not served last wins.
module rr_pick2
  import brisc_pkg::*;
(
  input  logic       req_1,
  input  logic       req_2,
  input  client_id_t last_served,
  output client_id_t winner,
  output logic       valid
);

  always_comb begin
    winner = CLIENT_1;
    valid  = req_1 | req_2;
    unique case (1'b1)
      (req_1 & req_2):  winner = rr_other(last_served);
      (req_2 & ~req_1): winner = CLIENT_2;
      (req_1 & ~req_2): winner = CLIENT_1;
      default:          winner = CLIENT_1;
    endcase
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter between icache and dcache onto one memory port.
// One transaction in flight; a watchdog aborts a silent memory.
module mem_arbiter_rr
  import brisc_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int CACHE_LINE_WIDTH = 128,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_1,
  input  logic                        store_1,
  input  logic                        word_1,
  input  logic [ADDRESS_WIDTH-1:0]    addr_1,
  input  logic [DATA_WIDTH-1:0]       data_1,
  input  logic                        req_2,
  input  logic                        store_2,
  input  logic                        word_2,
  input  logic [ADDRESS_WIDTH-1:0]    addr_2,
  input  logic [DATA_WIDTH-1:0]       data_2,
  output logic                        grant_1,
  output logic                        grant_2,
  output logic [CACHE_LINE_WIDTH-1:0] fill_data,
  output logic                        fill_valid,
  output logic                        mem_req,
  output logic                        mem_store,
  output logic                        mem_word,
  output logic [ADDRESS_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_data,
  input  logic [CACHE_LINE_WIDTH-1:0] mem_fill_data,
  input  logic                        mem_resp_valid,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Widths follow the parameters, so the package bundle is not reused here.
  typedef struct packed {
    logic                     store;
    logic                     word;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } lat_t;

  arb_state_e state_q;
  arb_state_e state_d;

  lat_t       lat_q;
  lat_t       pick_req;
  client_id_t winner_q;
  client_id_t last_q;
  client_id_t pick_id;
  logic       pick_valid;

  logic [CNT_W-1:0]            wd_cnt;
  logic                        wd_expired;
  logic [CACHE_LINE_WIDTH-1:0] fill_q;
  logic                        grant_1_q;
  logic                        grant_2_q;
  logic                        fill_valid_q;
  logic                        mem_req_q;
  logic                        tmo_q;

  rr_pick2 u_pick (
    .req_1       (req_1),
    .req_2       (req_2),
    .last_served (last_q),
    .winner      (pick_id),
    .valid       (pick_valid)
  );

  always_comb begin
    pick_req = '0;
    if (pick_id == CLIENT_2) begin
      pick_req.store = store_2;
      pick_req.word  = word_2;
      pick_req.addr  = addr_2;
      pick_req.data  = data_2;
    end else begin
      pick_req.store = store_1;
      pick_req.word  = word_1;
      pick_req.addr  = addr_1;
      pick_req.data  = data_1;
    end
  end

  assign wd_expired = (wd_cnt == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_resp_valid) state_d = RESP;
        else if (wd_expired) state_d = IDLE;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      winner_q     <= CLIENT_1;
      last_q       <= CLIENT_2;
      wd_cnt       <= '0;
      fill_q       <= '0;
      grant_1_q    <= 1'b0;
      grant_2_q    <= 1'b0;
      fill_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= (state_d == ISSUE);
      fill_valid_q <= (state_d == RESP);
      grant_1_q    <= (state_d == RESP) && (winner_q == CLIENT_1);
      grant_2_q    <= (state_d == RESP) && (winner_q == CLIENT_2);

      // Latched copy drives mem_* until the arbiter is idle again.
      if (state_q == IDLE && pick_valid) begin
        lat_q    <= pick_req;
        winner_q <= pick_id;
      end else if (state_q != IDLE && state_d == IDLE) begin
        lat_q <= '0;
      end

      if (state_q == ISSUE) begin
        wd_cnt <= '0;
      end else if (state_q == WAIT && !mem_resp_valid && !wd_expired) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end

      if (state_q == WAIT && !mem_resp_valid && wd_expired) begin
        tmo_q <= 1'b1;
      end

      if (state_q == WAIT && mem_resp_valid) begin
        fill_q <= mem_fill_data;
      end

      if (state_q == RESP) begin
        last_q <= winner_q;
      end
    end
  end

  assign grant_1     = grant_1_q;
  assign grant_2     = grant_2_q;
  assign fill_valid  = fill_valid_q;
  assign fill_data   = fill_q;
  assign mem_req     = mem_req_q;
  assign mem_store   = lat_q.store;
  assign mem_word    = lat_q.word;
  assign mem_addr    = lat_q.addr;
  assign mem_data    = lat_q.data;
  assign busy        = (state_q != IDLE);
  assign timeout_err = tmo_q;

endmodule
